// File: rtl/hex_entry_pkg.sv
// -----------------------------------------------------------------------------
// hex_entry_pkg
//   Shared definitions for the pushbutton hex-entry path: default cycle counts
//   for debounce and auto-repeat timing, the auto-repeat state encoding and a
//   helper that sizes a counter for a given terminal count.
//   Optional feature macro used by the consumers: BTN_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
package hex_entry_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int REPEAT_DELAY_DEF    = 50000000;
  localparam int REPEAT_RATE_DEF     = 10000000;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Width of a counter that runs 0 .. n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchronizer followed by a mismatch-count debouncer. The stable
//   level flips only after the synchronized input has disagreed with it for
//   DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
//   Ports:
//     CLK    in  system clock
//     RST    in  synchronous reset, active-high (everything to "released")
//     Raw    in  asynchronous raw button level, active-high
//     Stable out debounced level
//     Rise   out one-cycle pulse in the cycle Stable goes high
// -----------------------------------------------------------------------------
module btn_debounce
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic Raw,
  output logic Stable,
  output logic Rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes sync1 -> sync2 a real two-stage chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      Stable <= 1'b0;
      Rise   <= 1'b0;
    end else begin
      sync1 <= Raw;
      sync2 <= sync1;
      Rise  <= 1'b0;
      if (sync2 == Stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
        cnt    <= '0;
        Stable <= sync2;
        Rise   <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_hex_counter.sv
// -----------------------------------------------------------------------------
// button_hex_counter
//   Value source for the two-digit hex display. Three debounced pushbuttons
//   step an up/down counter or clear it; Changed pulses in every cycle Value
//   is written (a clear always counts, even when Value is already zero).
//   Priority: a clear press beats everything, and while clear is held all
//   up/down activity is ignored. Up and down held together never step.
//   Arithmetic wraps modulo 2^WIDTH.
//   Optional feature: define BTN_AUTOREPEAT_EN to add hold-to-repeat
//   (IDLE -> DELAY -> REPEAT) with REPEAT_DELAY / REPEAT_RATE timing; those
//   two parameters exist only in that build.
//   Ports:
//     CLK     in  system clock
//     RST     in  synchronous reset, active-high
//     BtnUp   in  raw increment button
//     BtnDn   in  raw decrement button
//     BtnClr  in  raw clear button
//     Value   out current value (WIDTH bits) to the seven-segment decoder
//     Changed out one-cycle pulse coincident with each Value update
// -----------------------------------------------------------------------------
module button_hex_counter
  import hex_entry_pkg::*;
#(
  parameter int WIDTH           = 8,
`ifdef BTN_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF,
`endif
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BtnUp,
  input  logic             BtnDn,
  input  logic             BtnClr,
  output logic [WIDTH-1:0] Value,
  output logic             Changed
);

  logic up_stable, up_rise;
  logic dn_stable, dn_rise;
  logic clr_stable, clr_rise;
  logic step_up, step_dn;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .CLK(CLK), .RST(RST), .Raw(BtnUp), .Stable(up_stable), .Rise(up_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .CLK(CLK), .RST(RST), .Raw(BtnDn), .Stable(dn_stable), .Rise(dn_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .CLK(CLK), .RST(RST), .Raw(BtnClr), .Stable(clr_stable), .Rise(clr_rise)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  rpt_state_t    rpt_state;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_up;     // direction being repeated: 1 = up, 0 = down
  logic          hold_ok;    // the repeated button is still the only one down
  logic          rpt_fire;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it holding a value (no latch).
  always_comb begin
    hold_ok  = rpt_up ? (up_stable & ~dn_stable) : (dn_stable & ~up_stable);
    rpt_fire = 1'b0;
    if (hold_ok) begin
      if (rpt_state == RPT_DELAY)  rpt_fire = (rpt_cnt == DELAY_LAST);
      if (rpt_state == RPT_REPEAT) rpt_fire = (rpt_cnt == RATE_LAST);
    end
    step_up = 1'b0;
    step_dn = 1'b0;
    if (!clr_stable) begin
      step_up = (up_rise & ~dn_stable) | (rpt_fire & rpt_up);
      step_dn = (dn_rise & ~up_stable) | (rpt_fire & ~rpt_up);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || clr_stable) begin
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
      rpt_up    <= 1'b0;
    end else begin
      case (rpt_state)
        RPT_IDLE: begin
          rpt_cnt <= '0;
          if (step_up || step_dn) begin
            rpt_state <= RPT_DELAY;
            rpt_up    <= step_up;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (!hold_ok) begin
            // Released, or the other direction joined in.
            rpt_state <= RPT_IDLE;
            rpt_cnt   <= '0;
          end else if (rpt_fire) begin
            rpt_state <= RPT_REPEAT;
            rpt_cnt   <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
        end
        default: begin
          rpt_state <= RPT_IDLE;
          rpt_cnt   <= '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    if (!clr_stable) begin
      step_up = up_rise & ~dn_stable;
      step_dn = dn_rise & ~up_stable;
    end
  end
`endif

  // NOTE: reset here is synchronous: it is just the highest-priority branch
  // inside the clocked block, so it only takes effect on a CLK edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Value   <= '0;
      Changed <= 1'b0;
    end else begin
      Changed <= 1'b0;
      if (clr_rise) begin
        Value   <= '0;
        Changed <= 1'b1;
      end else if (step_up) begin
        Value   <= Value + WIDTH'(1);
        Changed <= 1'b1;
      end else if (step_dn) begin
        Value   <= Value - WIDTH'(1);
        Changed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_hex_counter.sv
// -----------------------------------------------------------------------------
// tb_button_hex_counter
//   Directed bench for button_hex_counter with DEBOUNCE_CYCLES=4 (and, when
//   BTN_AUTOREPEAT_EN is defined, REPEAT_DELAY=20 / REPEAT_RATE=5). Inputs are
//   driven 1 time unit after a rising edge; outputs are sampled at the same
//   point, so a raw press driven after edge 0 shows up in Value after edge 7.
// -----------------------------------------------------------------------------
module tb_button_hex_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_dn, btn_clr;
  logic [7:0] value;
  logic       changed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_hex_counter #(
    .WIDTH(8),
`ifdef BTN_AUTOREPEAT_EN
    .REPEAT_DELAY(20),
    .REPEAT_RATE(5),
`endif
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .BtnUp(btn_up),
    .BtnDn(btn_dn),
    .BtnClr(btn_clr),
    .Value(value),
    .Changed(changed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles and count Changed pulses.
  task automatic settle(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick();
      if (changed === 1'b1) pulses++;
    end
  endtask

  // Hold the given buttons for 10 cycles, release everything for 10 cycles.
  task automatic press_release(input logic u, input logic d, input logic c, output int pulses);
    int p1, p2;
    btn_up = u; btn_dn = d; btn_clr = c;
    settle(10, p1);
    btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
    settle(10, p2);
    pulses = p1 + p2;
  endtask

  task automatic test_reset();
    int p;
    rst = 1'b1; btn_up = 1'b1; btn_dn = 1'b1; btn_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (value !== 8'h00 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset_cycle%0d: value=%h changed=%b expected value=00 changed=0", i, value, changed);
      end
    end
    rst = 1'b0;
    settle(10, p);
    checks++;
    if (value !== 8'h00 || p != 1) begin
      errors++;
      $display("FAIL reset_held_buttons: value=%h pulses=%0d expected value=00 pulses=1", value, p);
    end
    btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
    settle(10, p);
    checks++;
    if (value !== 8'h00 || p != 0) begin
      errors++;
      $display("FAIL reset_release: value=%h pulses=%0d expected value=00 pulses=0", value, p);
    end
  endtask

  task automatic test_single_press();
    int p;
    logic [7:0] ev;
    logic       ec;
    btn_up = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      ev = (k >= 7) ? 8'h01 : 8'h00;
      ec = (k == 7);
      checks++;
      if (value !== ev || changed !== ec) begin
        errors++;
        $display("FAIL single_press_k%0d: value=%h changed=%b expected value=%h changed=%b", k, value, changed, ev, ec);
      end
    end
    btn_up = 1'b0;
    settle(10, p);
    checks++;
    if (value !== 8'h01 || p != 0) begin
      errors++;
      $display("FAIL single_release: value=%h pulses=%0d expected value=01 pulses=0", value, p);
    end
  endtask

  task automatic test_bounce();
    int p;
    int total = 0;
    for (int i = 0; i < 8; i++) begin
      btn_up = (i % 2 == 0);
      settle(2, p);
      total += p;
    end
    btn_up = 1'b0;
    settle(10, p);
    total += p;
    checks++;
    if (value !== 8'h01 || total != 0) begin
      errors++;
      $display("FAIL bounce: value=%h pulses=%0d expected value=01 pulses=0", value, total);
    end
  endtask

  task automatic test_wrap();
    int p;
    press_release(1'b0, 1'b0, 1'b1, p);
    checks++;
    if (value !== 8'h00 || p != 1) begin
      errors++;
      $display("FAIL clear_nonzero: value=%h pulses=%0d expected value=00 pulses=1", value, p);
    end
    press_release(1'b0, 1'b1, 1'b0, p);
    checks++;
    if (value !== 8'hFF || p != 1) begin
      errors++;
      $display("FAIL wrap_down: value=%h pulses=%0d expected value=ff pulses=1", value, p);
    end
    press_release(1'b1, 1'b0, 1'b0, p);
    checks++;
    if (value !== 8'h00 || p != 1) begin
      errors++;
      $display("FAIL wrap_up: value=%h pulses=%0d expected value=00 pulses=1", value, p);
    end
    press_release(1'b0, 1'b0, 1'b1, p);
    checks++;
    if (value !== 8'h00 || p != 1) begin
      errors++;
      $display("FAIL clear_at_zero: value=%h pulses=%0d expected value=00 pulses=1", value, p);
    end
  endtask

  task automatic test_priority();
    int p;
    press_release(1'b1, 1'b1, 1'b0, p);
    checks++;
    if (value !== 8'h00 || p != 0) begin
      errors++;
      $display("FAIL up_dn_together: value=%h pulses=%0d expected value=00 pulses=0", value, p);
    end
    btn_up = 1'b1;
    settle(10, p);
    checks++;
    if (value !== 8'h01 || p != 1) begin
      errors++;
      $display("FAIL up_before_clr: value=%h pulses=%0d expected value=01 pulses=1", value, p);
    end
    btn_clr = 1'b1;
    settle(10, p);
    checks++;
    if (value !== 8'h00 || p != 1) begin
      errors++;
      $display("FAIL clr_over_up: value=%h pulses=%0d expected value=00 pulses=1", value, p);
    end
    btn_clr = 1'b0;
    settle(10, p);
    checks++;
    if (value !== 8'h00 || p != 0) begin
      errors++;
      $display("FAIL up_held_after_clr: value=%h pulses=%0d expected value=00 pulses=0", value, p);
    end
    btn_up = 1'b0;
    settle(10, p);
    press_release(1'b1, 1'b0, 1'b0, p);
    checks++;
    if (value !== 8'h01 || p != 1) begin
      errors++;
      $display("FAIL up_repress: value=%h pulses=%0d expected value=01 pulses=1", value, p);
    end
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int         p;
    int         steps;
    logic [7:0] ev;
    logic       ec;
    press_release(1'b0, 1'b0, 1'b1, p);
    btn_up = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      // Press step at 7, first repeat 20 later, then every 5 until release
      // (stable low after edge 66, so the last step is at 62).
      steps = (k >= 7) ? 1 : 0;
      ec    = (k == 7);
      for (int t = 27; t <= 62; t += 5) begin
        if (t <= k) steps++;
        if (t == k) ec = 1'b1;
      end
      ev = 8'(steps);
      checks++;
      if (value !== ev || changed !== ec) begin
        errors++;
        $display("FAIL autorepeat_k%0d: value=%h changed=%b expected value=%h changed=%b", k, value, changed, ev, ec);
      end
      if (k == 60) btn_up = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_priority();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
